// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory arbiter slice.
//
// Contents:
//   MIPS32_AW / MIPS32_DW : default memory word-address and data widths
//   arb_state_t           : arbiter FSM states (NORMAL, DRAIN, LOCKED)
//   owner_t               : tag of the port that owns the read in flight
package mips32_pkg;

    localparam int MIPS32_AW = 10;
    localparam int MIPS32_DW = 32;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2,
        OWN_H    = 2'd3
    } owner_t;

endpackage

// File: rtl/mips32_starve_cnt.sv
// Saturating starvation counter for one requester.
//
// Counts consecutive cycles in which the requester asked for memory and was
// refused. Any grant, or any cycle without a request, clears the count.
//
// Ports:
//   clk1  : clock
//   rst   : synchronous active-high reset (clears the count)
//   req   : requester is asking this cycle
//   gnt   : requester was granted this cycle
//   boost : count has reached STARVE_MAX; requester outranks everyone
module mips32_starve_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk1,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic boost
);

    // The counter is only 3 bits wide, so a threshold above 7 is clamped.
    localparam logic [2:0] LIMIT = (STARVE_MAX > 7) ? 3'd7 : 3'(STARVE_MAX);

    logic [2:0] cnt_p1;

    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt_p1 <= 3'd0;
        end else if (req && !gnt) begin
            if (cnt_p1 != 3'd7) begin
                cnt_p1 <= cnt_p1 + 3'd1;
            end
        end else begin
            cnt_p1 <= 3'd0;
        end
    end

    assign boost = (cnt_p1 >= LIMIT);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Three-port arbiter in front of a single synchronous-read memory.
//
// Ports served: instruction fetch (read only), data (read/write) and a
// host/loader port (read/write) that can also take exclusive ownership of the
// memory through h_lock. Grants are combinational in the request cycle; read
// data returns on the owning port one cycle later, straight from mem_rdata.
//
// Ports:
//   clk1, rst                           : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata
//   h_req/h_we/h_addr/h_wdata -> h_gnt/h_rvalid/h_rdata
//   h_lock                              : host requests exclusive ownership
//   mem_en/mem_we/mem_addr/mem_wdata    : memory command (to memory)
//   mem_rdata                           : memory read data, 1-cycle latency
//   locked                              : host owns the memory exclusively
//   busy                                : a read response is pending
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int AW         = MIPS32_AW,
    parameter int DW         = MIPS32_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst,
    // instruction fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // host / loader port
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    input  logic          h_lock,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          locked,
    output logic          busy
);

    arb_state_t state;
    arb_state_t state_nxt;
    owner_t     owner_p1;
    owner_t     owner_nxt;

    logic if_boost;
    logic h_boost;
    logic busy_raw;

    assign busy_raw = (owner_p1 != OWN_NONE);

    mips32_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_if_starve (
        .clk1 (clk1),
        .rst  (rst),
        .req  (if_req),
        .gnt  (if_gnt),
        .boost(if_boost)
    );

    mips32_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_h_starve (
        .clk1 (clk1),
        .rst  (rst),
        .req  (h_req),
        .gnt  (h_gnt),
        .boost(h_boost)
    );

    // ---- stage p0: arbitration and FSM next state (combinational) ----
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        h_gnt     = 1'b0;
        state_nxt = state;
        // All grants are suppressed while reset is held.
        if (!rst) begin
            case (state)
                ST_NORMAL: begin
                    // A boosted requester outranks the fixed order; IF
                    // wins if both IF and host are boosted.
                    if (if_boost && if_req) begin
                        if_gnt = 1'b1;
                    end else if (h_boost && h_req) begin
                        h_gnt = 1'b1;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                    end else if (if_req) begin
                        if_gnt = 1'b1;
                    end else if (h_req) begin
                        h_gnt = 1'b1;
                    end
                    if (h_lock) begin
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Only the host may touch memory while the last
                    // processor read drains out.
                    h_gnt = h_req;
                    if (!h_lock) begin
                        state_nxt = ST_NORMAL;
                    end else if (!busy_raw) begin
                        state_nxt = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    h_gnt = h_req;
                    if (!h_lock) begin
                        state_nxt = ST_NORMAL;
                    end
                end
                default: begin
                    state_nxt = ST_NORMAL;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = if_gnt | d_gnt | h_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_nxt = OWN_NONE;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            owner_nxt = d_we ? OWN_NONE : OWN_D;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            owner_nxt = OWN_IF;
        end else if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
            owner_nxt = h_we ? OWN_NONE : OWN_H;
        end
    end

    // ---- stage p1: state and read-owner registers ----
    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= ST_NORMAL;
            owner_p1 <= OWN_NONE;
        end else begin
            state    <= state_nxt;
            owner_p1 <= owner_nxt;
        end
    end

    // ---- response: route mem_rdata to the owning port ----
    // Gated with rst so a read in flight when reset arrives never appears.
    assign if_rvalid = !rst && (owner_p1 == OWN_IF);
    assign d_rvalid  = !rst && (owner_p1 == OWN_D);
    assign h_rvalid  = !rst && (owner_p1 == OWN_H);

    assign if_rdata = if_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid  ? mem_rdata : '0;
    assign h_rdata  = h_rvalid  ? mem_rdata : '0;

    assign busy   = !rst && busy_raw;
    assign locked = !rst && (state == ST_LOCKED);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
module tb_mips32_mem_arbiter;
    import mips32_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, h_req, h_we, h_lock;
    logic [9:0]  if_addr, d_addr, h_addr;
    logic [31:0] d_wdata, h_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid;
    logic [31:0] if_rdata, d_rdata, h_rdata;
    logic        mem_en, mem_we, locked, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk1 = ~clk1;

    mips32_mem_arbiter #(.AW(10), .DW(32), .STARVE_MAX(4)) dut (
        .clk1(clk1), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .h_lock(h_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .locked(locked), .busy(busy)
    );

    // Synchronous memory model, 1-cycle read latency.
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic        ifr;
        logic [9:0]  ifa;
        logic        dr;
        logic        dwe;
        logic [9:0]  da;
        logic [31:0] dwd;
        logic        hr;
        logic        hwe;
        logic [9:0]  ha;
        logic [31:0] hwd;
        logic [2:0]  gnt;    // {if, d, h}
        logic        we;
        logic [9:0]  maddr;
        logic [2:0]  rv;     // {if, d, h}
        logic [31:0] rdata;
        logic        busy;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ifr, input logic [9:0] ifa,
                         input logic dr, input logic dwe, input logic [9:0] da, input logic [31:0] dwd,
                         input logic hr, input logic hwe, input logic [9:0] ha, input logic [31:0] hwd,
                         input logic lock);
        if_req = ifr; if_addr = ifa;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        h_req = hr; h_we = hwe; h_addr = ha; h_wdata = hwd;
        h_lock = lock;
    endtask

    task automatic idle();
        drive(0, 10'd0, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
        mem[5] = 32'hDEAD_BEEF;

        //        ifr ifa    dr dwe da     dwd         hr hwe ha     hwd    gnt     we maddr  rv      rdata          busy
        // simultaneous IF + data read: data wins
        vecs[0]  = '{1, 10'd7, 1, 0, 10'd5, 32'd0,      0, 0, 10'd0, 32'd0, 3'b010, 0, 10'd5, 3'b000, 32'd0,         0};
        vecs[1]  = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b010, 32'hDEADBEEF,  1};
        // starvation of IF: 4 data grants, then IF boosted, then data
        vecs[2]  = '{1, 10'd20,1, 0, 10'd8, 32'd0,      0, 0, 10'd0, 32'd0, 3'b010, 0, 10'd8, 3'b000, 32'd0,         0};
        vecs[3]  = '{1, 10'd20,1, 0, 10'd8, 32'd0,      0, 0, 10'd0, 32'd0, 3'b010, 0, 10'd8, 3'b010, 32'hA5000008,  1};
        vecs[4]  = '{1, 10'd20,1, 0, 10'd8, 32'd0,      0, 0, 10'd0, 32'd0, 3'b010, 0, 10'd8, 3'b010, 32'hA5000008,  1};
        vecs[5]  = '{1, 10'd20,1, 0, 10'd8, 32'd0,      0, 0, 10'd0, 32'd0, 3'b010, 0, 10'd8, 3'b010, 32'hA5000008,  1};
        vecs[6]  = '{1, 10'd20,1, 0, 10'd8, 32'd0,      0, 0, 10'd0, 32'd0, 3'b100, 0, 10'd20,3'b010, 32'hA5000008,  1};
        vecs[7]  = '{1, 10'd20,1, 0, 10'd8, 32'd0,      0, 0, 10'd0, 32'd0, 3'b010, 0, 10'd8, 3'b100, 32'hA5000014,  1};
        vecs[8]  = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b010, 32'hA5000008,  1};
        vecs[9]  = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b000, 32'd0,         0};
        // back-to-back IF reads 0,1,2
        vecs[10] = '{1, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b100, 0, 10'd0, 3'b000, 32'd0,         0};
        vecs[11] = '{1, 10'd1, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b100, 0, 10'd1, 3'b100, 32'hA5000000,  1};
        vecs[12] = '{1, 10'd2, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b100, 0, 10'd2, 3'b100, 32'hA5000001,  1};
        vecs[13] = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b100, 32'hA5000002,  1};
        vecs[14] = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b000, 32'd0,         0};
        // data write beats host read; host read next; read back the write
        vecs[15] = '{0, 10'd0, 1, 1, 10'd30,32'h55,     1, 0, 10'd40,32'd0, 3'b010, 1, 10'd30,3'b000, 32'd0,         0};
        vecs[16] = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      1, 0, 10'd40,32'd0, 3'b001, 0, 10'd40,3'b000, 32'd0,         0};
        vecs[17] = '{0, 10'd0, 1, 0, 10'd30,32'd0,      0, 0, 10'd0, 32'd0, 3'b010, 0, 10'd30,3'b001, 32'hA5000028,  1};
        vecs[18] = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b010, 32'h55,        1};
        vecs[19] = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b000, 32'd0,         0};
        // host starvation against data
        vecs[20] = '{0, 10'd0, 1, 0, 10'd3, 32'd0,      1, 0, 10'd4, 32'd0, 3'b010, 0, 10'd3, 3'b000, 32'd0,         0};
        vecs[21] = '{0, 10'd0, 1, 0, 10'd3, 32'd0,      1, 0, 10'd4, 32'd0, 3'b010, 0, 10'd3, 3'b010, 32'hA5000003,  1};
        vecs[22] = '{0, 10'd0, 1, 0, 10'd3, 32'd0,      1, 0, 10'd4, 32'd0, 3'b010, 0, 10'd3, 3'b010, 32'hA5000003,  1};
        vecs[23] = '{0, 10'd0, 1, 0, 10'd3, 32'd0,      1, 0, 10'd4, 32'd0, 3'b010, 0, 10'd3, 3'b010, 32'hA5000003,  1};
        vecs[24] = '{0, 10'd0, 1, 0, 10'd3, 32'd0,      1, 0, 10'd4, 32'd0, 3'b001, 0, 10'd4, 3'b010, 32'hA5000003,  1};
        vecs[25] = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b001, 32'hA5000004,  1};
        vecs[26] = '{0, 10'd0, 0, 0, 10'd0, 32'd0,      0, 0, 10'd0, 32'd0, 3'b000, 0, 10'd0, 3'b000, 32'd0,         0};

        // Reset with requests pending: everything must stay quiet.
        rst = 1'b1;
        drive(1, 10'd1, 1, 0, 10'd2, 32'd0, 1, 0, 10'd3, 32'd0, 0);
        @(negedge clk1); @(negedge clk1); #2;
        chk("rst gnt", {if_gnt, d_gnt, h_gnt}, 3'b000);
        chk("rst mem_en", mem_en, 1'b0);
        chk("rst mem_we", mem_we, 1'b0);
        chk("rst rvalid", {if_rvalid, d_rvalid, h_rvalid}, 3'b000);
        chk("rst busy/locked", {busy, locked}, 2'b00);
        @(negedge clk1);
        rst = 1'b0;
        idle();

        // Table-driven section
        for (int i = 0; i < NV; i++) begin
            @(negedge clk1);
            drive(vecs[i].ifr, vecs[i].ifa, vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd,
                  vecs[i].hr, vecs[i].hwe, vecs[i].ha, vecs[i].hwd, 0);
            #2;
            chk($sformatf("v%0d gnt", i), {if_gnt, d_gnt, h_gnt}, vecs[i].gnt);
            chk($sformatf("v%0d mem_en", i), mem_en, |vecs[i].gnt);
            chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].we);
            if (|vecs[i].gnt) chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
            chk($sformatf("v%0d rvalid", i), {if_rvalid, d_rvalid, h_rvalid}, vecs[i].rv);
            chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].rv[2] ? vecs[i].rdata : 32'd0);
            chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].rv[1] ? vecs[i].rdata : 32'd0);
            chk($sformatf("v%0d h_rdata", i), h_rdata, vecs[i].rv[0] ? vecs[i].rdata : 32'd0);
            chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d locked", i), locked, 1'b0);
        end

        // Lock drain: IF read granted, then h_lock rises.
        @(negedge clk1);
        drive(1, 10'd9, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0);
        #2 chk("lk if_gnt", if_gnt, 1'b1);
        @(negedge clk1);
        drive(0, 10'd0, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 1);
        #2;
        chk("lk if_rvalid", if_rvalid, 1'b1);
        chk("lk if_rdata", if_rdata, 32'hA500_0009);
        chk("lk busy", busy, 1'b1);
        chk("lk locked early", locked, 1'b0);
        @(negedge clk1);
        drive(1, 10'd9, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 1);
        #2;
        chk("dr state", 32'(dut.state), 32'(ST_DRAIN));
        chk("dr if_gnt", if_gnt, 1'b0);
        chk("dr mem_en", mem_en, 1'b0);
        chk("dr busy/locked", {busy, locked}, 2'b00);
        @(negedge clk1); #2;
        chk("lkd locked", locked, 1'b1);
        chk("lkd if_gnt", if_gnt, 1'b0);

        // Host write while locked; data request must be ignored.
        @(negedge clk1);
        drive(1, 10'd9, 1, 0, 10'd5, 32'd0, 1, 1, 10'h3FF, 32'h1234_5678, 1);
        #2;
        chk("hw gnt", {if_gnt, d_gnt, h_gnt}, 3'b001);
        chk("hw mem_we", mem_we, 1'b1);
        chk("hw mem_addr", mem_addr, 10'h3FF);
        chk("hw mem_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk1);
        drive(1, 10'd9, 1, 0, 10'd5, 32'd0, 0, 0, 10'd0, 32'd0, 1);
        #2;
        chk("hw no rvalid", {if_rvalid, d_rvalid, h_rvalid}, 3'b000);
        chk("hw d ignored", d_gnt, 1'b0);
        chk("hw busy", busy, 1'b0);
        @(negedge clk1);
        idle();
        #2 chk("unlk locked still", locked, 1'b1);
        @(negedge clk1);
        drive(0, 10'd0, 1, 0, 10'h3FF, 32'd0, 0, 0, 10'd0, 32'd0, 0);
        #2;
        chk("unlk locked", locked, 1'b0);
        chk("unlk d_gnt", d_gnt, 1'b1);
        @(negedge clk1);
        idle();
        #2;
        chk("unlk d_rvalid", d_rvalid, 1'b1);
        chk("unlk d_rdata", d_rdata, 32'h1234_5678);

        // Reset in the middle of a read.
        @(negedge clk1);
        drive(0, 10'd0, 1, 0, 10'd5, 32'd0, 0, 0, 10'd0, 32'd0, 0);
        #2 chk("mr d_gnt", d_gnt, 1'b1);
        @(negedge clk1);
        rst = 1'b1;
        drive(1, 10'd1, 1, 0, 10'd5, 32'd0, 1, 0, 10'd0, 32'd0, 0);
        #2;
        chk("mr rvalid", {if_rvalid, d_rvalid, h_rvalid}, 3'b000);
        chk("mr d_rdata", d_rdata, 32'd0);
        chk("mr gnt", {if_gnt, d_gnt, h_gnt}, 3'b000);
        chk("mr mem", {mem_en, mem_we}, 2'b00);
        chk("mr busy/locked", {busy, locked}, 2'b00);
        @(negedge clk1);
        rst = 1'b0;
        idle();
        #2;
        chk("mr after rvalid", {if_rvalid, d_rvalid, h_rvalid}, 3'b000);
        chk("mr after busy", busy, 1'b0);
        chk("mr after state", 32'(dut.state), 32'(ST_NORMAL));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips32_mem_arbiter.md
MIPS32_MEM_ARBITER -- requirements
Module: mips32_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10: memory word-address width (1024 words).
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4: consecutive denied cycles before a requester is boosted.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk1 (input, 1 bit, the clock) and rst (input, 1 bit, the reset).
REQ-005 SHALL have the instruction-fetch port: if_req in 1; if_addr in AW; if_gnt out 1; if_rvalid out 1; if_rdata out DW.
REQ-006 SHALL have the data port: d_req in 1; d_we in 1; d_addr in AW; d_wdata in DW; d_gnt out 1; d_rvalid out 1; d_rdata out DW.
REQ-007 SHALL have the host/loader port: h_req in 1; h_we in 1; h_addr in AW; h_wdata in DW; h_gnt out 1; h_rvalid out 1; h_rdata out DW.
REQ-008 SHALL have the host lock input: h_lock in 1; 1 requests exclusive memory ownership for the host.
REQ-009 SHALL have the memory-side port: mem_en out 1; mem_we out 1; mem_addr out AW; mem_wdata out DW; mem_rdata in DW (synchronous read, 1-cycle latency).
REQ-010 SHALL have the status outputs: locked out 1; busy out 1 (a read response is pending).

Function
REQ-011 SHALL grant at most one of if_gnt/d_gnt/h_gnt per cycle; the grant is combinational in the request cycle.
REQ-012 SHALL, on a grant, drive mem_en=1, with mem_we/mem_addr/mem_wdata taken from the granted port (mem_we=0 for IF) in the same cycle; with no grant, mem_en=0 and mem_we=0.
REQ-013 SHALL use NORMAL-state priority data > IF > host, except that a boosted requester outranks all others; if IF and host are both boosted, IF wins.
REQ-014 SHALL keep a 3-bit saturating starvation counter each for IF and host: increment when requesting and not granted, clear on grant or when not requesting; boosted when count >= STARVE_MAX.
REQ-015 SHALL assert the granted port's rvalid for exactly one cycle, the cycle after a granted read, with rdata = mem_rdata in that cycle; a write produces no rvalid.
REQ-016 SHALL drive every rdata to 0 whenever its rvalid=0.
REQ-017 SHALL register the read-owner tag (NONE/IF/D/H) and drive busy=1 while the tag is not NONE.
REQ-018 SHALL implement an FSM with states NORMAL, DRAIN and LOCKED.
REQ-019 SHALL transition NORMAL->DRAIN when h_lock=1; no IF/data grants in DRAIN; host grants are allowed in DRAIN.
REQ-020 SHALL transition DRAIN->LOCKED when busy=0, and DRAIN->NORMAL if h_lock drops first.
REQ-021 SHALL, in LOCKED, grant only the host; locked=1 only in LOCKED; LOCKED->NORMAL when h_lock=0.
REQ-022 SHALL let a request asserted in the same cycle as h_lock rise still arbitrate under NORMAL rules, since the state is still NORMAL.
REQ-023 SHALL treat back-to-back reads as full throughput: a new grant is legal in the rvalid cycle of the previous read.
REQ-024 SHALL pass addresses through unmodified; wrap-around and out-of-range handling is the requester's responsibility.

Reset
REQ-025 SHALL, on rst=1 at a clk1 edge: state=NORMAL, both counters=0, owner tag=NONE.
REQ-026 SHALL hold all gnt, rvalid, mem_en, mem_we, locked and busy outputs at 0 and all rdata at 0 during reset.
REQ-027 SHALL discard a read in flight when reset is asserted (no rvalid after reset).

Structure
REQ-028 SHALL put the FSM state encoding, owner-tag encoding and default AW/DW in shared package mips32_pkg.
REQ-029 SHALL implement the saturating starvation counter as sub-module mips32_starve_cnt, instantiated twice.

Verification
REQ-030 SHALL verify the simultaneous request: if_req=d_req=1 (d_we=0, d_addr=5, mem[5]=0xDEADBEEF) -> d_gnt=1, if_gnt=0; next cycle d_rvalid=1, d_rdata=0xDEADBEEF.
REQ-031 SHALL verify starvation: d_req and if_req held at 1 for 6 cycles -> d_gnt for cycles 1-4, if_gnt in cycle 5, d_gnt in cycle 6.
REQ-032 SHALL verify the lock drain: IF read granted, h_lock=1 next cycle -> state DRAIN; if_rvalid delivered; LOCKED one cycle after busy=0; locked=1; if_req blocked.
REQ-033 SHALL verify a host write in LOCKED: h_we=1, h_addr=0x3FF, h_wdata=0x12345678 -> mem_we=1 and mem_addr=0x3FF the same cycle; no h_rvalid; d_req is ignored.
REQ-034 SHALL verify reset mid-read: a granted read then rst=1 -> no rvalid; all outputs 0; state NORMAL.
REQ-035 SHALL verify back-to-back IF reads at addresses 0,1,2 -> if_rvalid high for 3 consecutive cycles with the matching data.
